// File: rtl/io_timer_pkg.sv
// Shared constants for io_timer: register offsets, CTRL/STATUS bit positions and FSM encoding.
// The CMP register offset is only decoded when IO_TIMER_PWM_EN is defined.
package io_timer_pkg;

    localparam logic [2:0] OFF_CTRL     = 3'd0;
    localparam logic [2:0] OFF_LOAD     = 3'd1;
    localparam logic [2:0] OFF_COUNT    = 3'd2;
    localparam logic [2:0] OFF_STATUS   = 3'd3;
    localparam logic [2:0] OFF_PRESCALE = 3'd4;
    localparam logic [2:0] OFF_CMP      = 3'd5;

`ifdef IO_TIMER_PWM_EN
    localparam int unsigned NUM_REGS = 6;
`else
    localparam int unsigned NUM_REGS = 5;
`endif

    localparam int unsigned CTRL_EN     = 0;
    localparam int unsigned CTRL_RELOAD = 1;
    localparam int unsigned CTRL_IRQEN  = 2;
    localparam int unsigned STATUS_EXP  = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/io_timer_prescaler.sv
// Free-running modulo counter: tick pulses once every prescale+1 clocks while run is high.
// clear restarts the count at 0 and suppresses the tick on that edge.
module io_timer_prescaler #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             clear,
    input  logic [WIDTH-1:0] prescale,
    output logic             tick
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = run && !clear && (cnt_q == prescale);
        cnt_d = cnt_q;
        if (clear || tick) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/io_timer.sv
// Memory-mapped programmable down-counter with sticky expiry flag and level irq.
// Define IO_TIMER_PWM_EN to add the CMP register (offset 5) and the pwm_out output.
module io_timer
    import io_timer_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 16,
    parameter int unsigned           ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 8'h10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] bus_addr,
    inout  wire  [DATA_WIDTH-1:0] bus_data,
    input  logic                  read,
    input  logic                  write,
    output logic                  irq
`ifdef IO_TIMER_PWM_EN
    ,
    output logic                  pwm_out
`endif
);

    state_e                state_q, state_d;
    logic                  reload_q, reload_d;
    logic                  irqen_q, irqen_d;
    logic                  expired_q, expired_d;
    logic [DATA_WIDTH-1:0] load_q, load_d;
    logic [DATA_WIDTH-1:0] count_q, count_d;
    logic [DATA_WIDTH-1:0] prescale_q, prescale_d;
    logic [DATA_WIDTH-1:0] rdata;

    logic [ADDR_WIDTH-1:0] off_full;
    logic [2:0]            off;
    logic                  hit, wr_en, rd_en;
    logic                  wr_ctrl, wr_load, wr_status, wr_prescale;
    logic                  start, stop, pre_run, pre_clear, tick;

    assign off_full = bus_addr - BASE_ADDR;
    assign off      = off_full[2:0];
    assign hit      = (bus_addr >= BASE_ADDR) && (off_full < ADDR_WIDTH'(NUM_REGS));
    assign wr_en    = write && hit;
    // A simultaneous write takes priority; the bus is then owned by the CPU.
    assign rd_en    = read && !write && hit;

    assign wr_ctrl     = wr_en && (off == OFF_CTRL);
    assign wr_load     = wr_en && (off == OFF_LOAD);
    assign wr_status   = wr_en && (off == OFF_STATUS);
    assign wr_prescale = wr_en && (off == OFF_PRESCALE);

    assign start     = wr_ctrl && bus_data[CTRL_EN];
    assign stop      = wr_ctrl && !bus_data[CTRL_EN];
    assign pre_run   = (state_q == ST_RUN) && !stop;
    assign pre_clear = ((state_q == ST_IDLE) && start) || ((state_q == ST_RUN) && wr_prescale);

    io_timer_prescaler #(
        .WIDTH(DATA_WIDTH)
    ) u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .run     (pre_run),
        .clear   (pre_clear),
        .prescale(prescale_q),
        .tick    (tick)
    );

    always_comb begin
        state_d    = state_q;
        reload_d   = reload_q;
        irqen_d    = irqen_q;
        expired_d  = expired_q;
        load_d     = load_q;
        count_d    = count_q;
        prescale_d = prescale_q;

        if (wr_ctrl) begin
            reload_d = bus_data[CTRL_RELOAD];
            irqen_d  = bus_data[CTRL_IRQEN];
        end
        if (wr_load) begin
            load_d = bus_data;
            if (state_q == ST_IDLE) begin
                count_d = bus_data;
            end
        end
        if (wr_prescale) begin
            prescale_d = bus_data;
        end
        if (wr_status && bus_data[STATUS_EXP]) begin
            expired_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    count_d = load_q;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    if (count_q != '0) begin
                        count_d = count_q - 1'b1;
                    end else begin
                        // Expiry overrides a same-cycle STATUS clear.
                        expired_d = 1'b1;
                        if (reload_q) begin
                            count_d = load_q;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            reload_q   <= 1'b0;
            irqen_q    <= 1'b0;
            expired_q  <= 1'b0;
            load_q     <= '0;
            count_q    <= '0;
            prescale_q <= '0;
        end else begin
            state_q    <= state_d;
            reload_q   <= reload_d;
            irqen_q    <= irqen_d;
            expired_q  <= expired_d;
            load_q     <= load_d;
            count_q    <= count_d;
            prescale_q <= prescale_d;
        end
    end

    assign irq = expired_q && irqen_q;

`ifdef IO_TIMER_PWM_EN
    logic [DATA_WIDTH-1:0] cmp_q;
    logic                  pwm_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cmp_q <= '0;
            pwm_q <= 1'b0;
        end else begin
            if (wr_en && (off == OFF_CMP)) begin
                cmp_q <= bus_data;
            end
            pwm_q <= (state_q == ST_RUN) && (count_q < cmp_q);
        end
    end

    assign pwm_out = pwm_q;
`endif

    always_comb begin
        rdata = '0;
        case (off)
            OFF_CTRL: begin
                rdata[CTRL_EN]     = (state_q == ST_RUN);
                rdata[CTRL_RELOAD] = reload_q;
                rdata[CTRL_IRQEN]  = irqen_q;
            end
            OFF_LOAD:            rdata = load_q;
            OFF_COUNT:           rdata = count_q;
            OFF_STATUS:          rdata[STATUS_EXP] = expired_q;
            OFF_PRESCALE:        rdata = prescale_q;
`ifdef IO_TIMER_PWM_EN
            OFF_CMP:             rdata = cmp_q;
`endif
            default:             rdata = '0;
        endcase
    end

    assign bus_data = rd_en ? rdata : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_io_timer.sv
// Randomized and directed bench for io_timer, checked against a register-level reference model.
// Build with IO_TIMER_PWM_EN defined to also exercise CMP and pwm_out.
module tb_io_timer;

`ifdef IO_TIMER_PWM_EN
    localparam int NREGS = 6;
`else
    localparam int NREGS = 5;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  bus_addr;
    logic        read, write;
    logic        irq;
    logic        tb_drive;
    logic [15:0] tb_wdata;
    tri1  [15:0] bus_data;
`ifdef IO_TIMER_PWM_EN
    logic        pwm_out;
`endif

    assign bus_data = tb_drive ? tb_wdata : 16'hzzzz;

    io_timer dut (
        .clk     (clk),
        .reset   (reset),
        .bus_addr(bus_addr),
        .bus_data(bus_data),
        .read    (read),
        .write   (write),
        .irq     (irq)
`ifdef IO_TIMER_PWM_EN
        ,
        .pwm_out (pwm_out)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference model: architectural registers plus the prescale divider position.
    bit          m_en, m_reload, m_irqen, m_exp, m_pwm;
    logic [15:0] m_load, m_count, m_pre, m_div, m_cmp;

    function automatic bit m_hit(input logic [7:0] a);
        return (int'(a) >= 16) && (int'(a) < 16 + NREGS);
    endfunction

    function automatic logic [15:0] m_read(input int off);
        case (off)
            0:       return {13'b0, m_irqen, m_reload, m_en};
            1:       return m_load;
            2:       return m_count;
            3:       return {15'b0, m_exp};
            4:       return m_pre;
            5:       return m_cmp;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic model_reset();
        m_en = 0; m_reload = 0; m_irqen = 0; m_exp = 0; m_pwm = 0;
        m_load = 0; m_count = 0; m_pre = 0; m_div = 0; m_cmp = 0;
    endtask

    task automatic model_edge(input bit rst, input bit wr, input logic [7:0] a,
                              input logic [15:0] d);
        int          off;
        bit          hw, start, stop, tick, expire;
        bit          n_en, n_reload, n_irqen, n_exp;
        logic [15:0] n_load, n_count, n_pre, n_div, n_cmp;
        if (rst) begin
            model_reset();
            return;
        end
        off = int'(a) - 16;
        hw  = wr && m_hit(a);
        n_en = m_en; n_reload = m_reload; n_irqen = m_irqen; n_exp = m_exp;
        n_load = m_load; n_count = m_count; n_pre = m_pre; n_div = m_div; n_cmp = m_cmp;
        start  = !m_en && hw && off == 0 && d[0];
        stop   = m_en && hw && off == 0 && !d[0];
        tick   = 0;
        expire = 0;
        m_pwm  = m_en && (m_count < m_cmp);
        if (m_en && !stop) begin
            if (hw && off == 4) n_div = 0;
            else if (m_div == m_pre) begin tick = 1; n_div = 0; end
            else n_div = m_div + 1;
        end
        if (tick) begin
            if (m_count > 0) n_count = m_count - 1;
            else begin
                expire = 1;
                if (m_reload) n_count = m_load;
                else n_en = 0;
            end
        end
        if (hw) begin
            case (off)
                0: begin n_reload = d[1]; n_irqen = d[2]; end
                1: begin n_load = d; if (!m_en) n_count = d; end
                3: if (d[0]) n_exp = 0;
                4: n_pre = d;
                5: n_cmp = d;
                default: ;
            endcase
        end
        if (expire) n_exp = 1;
        if (start) begin n_en = 1; n_count = m_load; n_div = 0; end
        if (stop) n_en = 0;
        m_en = n_en; m_reload = n_reload; m_irqen = n_irqen; m_exp = n_exp;
        m_load = n_load; m_count = n_count; m_pre = n_pre; m_div = n_div; m_cmp = n_cmp;
    endtask

    // One bus cycle: drive, sample at negedge against the model, then advance past the edge.
    task automatic cycle(input bit rst, input bit wr, input bit rd, input logic [7:0] a,
                         input logic [15:0] d, output logic [15:0] obs);
        reset = rst; write = wr; read = rd; bus_addr = a; tb_wdata = d; tb_drive = wr;
        @(negedge clk);
        obs = bus_data;
        check_eq("irq", {15'b0, irq}, {15'b0, m_irqen && m_exp});
        if (rd && !wr && m_hit(a)) check_eq("rdata", obs, m_read(int'(a) - 16));
        else if (wr) check_eq("bus_wr", obs, d);
        else check_eq("bus_hiz", obs, 16'hffff);
`ifdef IO_TIMER_PWM_EN
        check_eq("pwm", {15'b0, pwm_out}, {15'b0, m_pwm});
`endif
        @(posedge clk);
        model_edge(rst, wr, a, d);
        #1;
    endtask

    logic [15:0] obs;

    task automatic wr_reg(input int off, input logic [15:0] d);
        cycle(1'b0, 1'b1, 1'b0, 8'(16 + off), d, obs);
    endtask

    task automatic rd_chk(input string tag, input int off, input logic [15:0] exp);
        cycle(1'b0, 1'b0, 1'b1, 8'(16 + off), 16'h0, obs);
        check_eq(tag, obs, exp);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, 8'h10, 16'h0, obs);
    endtask

    task automatic irq_chk(input string tag, input bit exp);
        check_eq(tag, {15'b0, irq}, {15'b0, exp});
    endtask

    int          r, off;
    logic [7:0]  a;
    logic [15:0] d;

    initial begin
        reset = 1'b1; read = 1'b0; write = 1'b0; bus_addr = 8'h00;
        tb_drive = 1'b0; tb_wdata = 16'h0;
        repeat (2) @(posedge clk);
        model_reset();
        #1;

        // Reset state and bus release.
        for (int i = 0; i < 5; i++) rd_chk("reset_rd", i, 16'h0000);
        irq_chk("reset_irq", 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 8'h10, 16'h0, obs);
        check_eq("hiz_noread", obs, 16'hffff);
        cycle(1'b0, 1'b0, 1'b1, 8'h20, 16'h0, obs);
        check_eq("hiz_outside", obs, 16'hffff);
`ifndef IO_TIMER_PWM_EN
        cycle(1'b0, 1'b0, 1'b1, 8'h15, 16'h0, obs);
        check_eq("hiz_off5", obs, 16'hffff);
`endif

        // One-shot: COUNT 3,2,1,0 then expiry disables.
        wr_reg(1, 16'd3);
        wr_reg(4, 16'd0);
        wr_reg(0, 16'h0001);
        rd_chk("oneshot_c3", 2, 16'd3);
        rd_chk("oneshot_c2", 2, 16'd2);
        rd_chk("oneshot_c1", 2, 16'd1);
        rd_chk("oneshot_c0", 2, 16'd0);
        rd_chk("oneshot_exp", 3, 16'h0001);
        rd_chk("oneshot_ctrl", 0, 16'h0000);
        rd_chk("oneshot_hold", 2, 16'd0);

        // Auto-reload with prescale 1: expiry every 6 clocks, irq handling.
        wr_reg(3, 16'h0001);
        wr_reg(1, 16'd2);
        wr_reg(4, 16'd1);
        wr_reg(0, 16'h0007);
        irq_chk("ar_irq_e0", 1'b0);
        for (int i = 0; i < 5; i++) begin idle(); irq_chk("ar_irq_low", 1'b0); end
        idle();
        irq_chk("ar_irq_first", 1'b1);
        wr_reg(3, 16'h0001);
        irq_chk("ar_irq_clr", 1'b0);
        for (int i = 0; i < 4; i++) begin idle(); irq_chk("ar_irq_low2", 1'b0); end
        idle();
        irq_chk("ar_irq_again", 1'b1);
        for (int i = 0; i < 5; i++) begin idle(); irq_chk("ar_irq_hold", 1'b1); end
        wr_reg(3, 16'h0001);
        irq_chk("clr_on_expiry", 1'b1);
        rd_chk("clr_on_expiry_st", 3, 16'h0001);
        wr_reg(0, 16'h0000);
        wr_reg(3, 16'h0001);
        irq_chk("ar_irq_final", 1'b0);

        // Stop mid-count, LOAD copy in IDLE, COUNT is read-only.
        wr_reg(4, 16'd0);
        wr_reg(1, 16'd5);
        wr_reg(0, 16'h0001);
        idle();
        idle();
        wr_reg(0, 16'h0000);
        rd_chk("stop_count", 2, 16'd3);
        rd_chk("stop_ctrl", 0, 16'h0000);
        wr_reg(1, 16'd9);
        rd_chk("idle_load_copy", 2, 16'd9);
        wr_reg(2, 16'd7);
        rd_chk("count_ro", 2, 16'd9);

        // Read and write together: write wins, bus stays with the CPU.
        cycle(1'b0, 1'b1, 1'b1, 8'h11, 16'h1234, obs);
        check_eq("rdwr_bus", obs, 16'h1234);
        rd_chk("rdwr_load", 1, 16'h1234);

`ifdef IO_TIMER_PWM_EN
        // PWM: high while COUNT is 1 or 0, registered one clock later.
        wr_reg(5, 16'd2);
        wr_reg(1, 16'd3);
        wr_reg(4, 16'd0);
        wr_reg(0, 16'h0003);
        for (int i = 0; i < 8; i++) begin
            idle();
            check_eq("pwm_pattern", {15'b0, pwm_out}, {15'b0, bit'((i % 4) >= 2)});
        end
        wr_reg(0, 16'h0000);
        wr_reg(3, 16'h0001);
`endif

        // Randomized traffic against the model, including occasional resets.
        for (int i = 0; i < 600; i++) begin
            r   = int'($urandom_range(0, 99));
            off = int'($urandom_range(0, 6));
            a   = (r % 17 == 0) ? 8'($urandom_range(0, 255)) : 8'(16 + off);
            d   = 16'($urandom_range(0, 7));
            if (r < 2) cycle(1'b1, 1'b0, 1'b0, a, d, obs);
            else if (r < 40) cycle(1'b0, 1'b1, 1'b0, a, d, obs);
            else if (r < 80) cycle(1'b0, 1'b0, 1'b1, a, d, obs);
            else if (r < 85) cycle(1'b0, 1'b1, 1'b1, a, d, obs);
            else cycle(1'b0, 1'b0, 1'b0, a, d, obs);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
